pipe_stage_skid: RTL
====================

# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake and a 2-entry skid buffer. It replaces fixed-field inter-stage latches: the upstream stage packs its fields into one payload bus, and this block registers it toward the downstream stage. Unlike a plain latch, a stall holds data without loss, and a flush kills in-flight entries. It also sustains one transfer per cycle with no combinational path from `out_ready` to `in_ready`, and provides saturating stall and flush counters for performance monitoring.

## Interface
Parameters:
- `DATA_WIDTH`, default 128: payload width in bits.
- `RESET_VALUE`, default 0: value loaded into both data registers on reset or flush.
- `CNT_WIDTH`, default 16: width of each performance counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; clock is clk.
- `flush`  in  1  synchronous kill of all stored entries.
- `in_valid`  in  1  upstream payload valid.
- `in_ready`  out  1  stage can accept; equals (occupancy != 2); depends only on registered state.
- `in_data`  in  DATA_WIDTH  upstream payload.
- `out_valid`  out  1  main entry valid.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  DATA_WIDTH  main register contents.
- `occupancy`  out  2  stored entries, 0..2.
- `stall_cnt`  out  CNT_WIDTH  cycles with out_valid=1 and out_ready=0; saturating.
- `flush_cnt`  out  CNT_WIDTH  cycles with flush=1 and reset=0; saturating.

## Operation
- Storage: a main register (drives `out_data`) and a skid register, each with a valid bit.
- State is encoded by `occupancy`: EMPTY (0), ONE (main valid), TWO (main and skid valid).
- Accept: `acc = in_valid & in_ready`. Release: `rel = out_valid & out_ready`.
- EMPTY: on acc, main <= in_data and go to ONE; otherwise stay.
- ONE:
  - acc and rel: main <= in_data; stay in ONE.
  - acc only: skid <= in_data; go to TWO.
  - rel only: go to EMPTY; main data is kept but marked invalid.
  - neither: hold.
- TWO: `in_ready` = 0. On rel, main <= skid and go to ONE. Otherwise hold both registers.
- Stall: data registers change only on the loads listed above. No entry is ever dropped or duplicated, and order is FIFO.
- Priority: reset > flush > normal operation.
- Flush:
  - Next state is EMPTY; main and skid <= RESET_VALUE.
  - An acc in the same cycle is discarded.
  - An rel in the same cycle counts as delivered, since the consumer sampled it.
- Counters:
  - `stall_cnt` increments on out_valid & !out_ready, including the flush cycle.
  - `flush_cnt` increments on flush & !reset.
  - Both stick at 2^CNT_WIDTH-1.
- Reset values:
  - `out_valid` = 0; `in_ready` = 1; `occupancy` = 0.
  - `out_data` = RESET_VALUE; skid register = RESET_VALUE.
  - `stall_cnt` = 0; `flush_cnt` = 0.

## Timing
- Latency: a payload accepted at edge N in EMPTY, or in ONE with rel, appears on `out_data` with `out_valid`=1 after edge N (one cycle).
- Throughput: one transfer per cycle while `out_ready`=1.
- `in_ready` falls the cycle after the skid buffer fills. It rises the cycle after the first rel in TWO.
- `flush` or `reset` asserted at edge N: after edge N, `out_valid`=0 and `in_ready`=1. A new acc is possible at edge N+1.
- Counter values reflect events up to the previous edge.

## Test plan
- Reset: hold reset 2 cycles with in_valid=1, in_data=0xAA -> out_valid=0, in_ready=1, occupancy=0, out_data=0, both counters 0.
- Streaming: out_ready=1, send 0x1..0x8 back-to-back -> out_data reads 0x1..0x8 on consecutive cycles starting 1 cycle after the first accept; in_ready stays 1; stall_cnt=0.
- Backpressure:
  - Stimulus: out_ready=0, offer 0x10, 0x11, 0x12.
  - Response: 0x10 and 0x11 accepted; occupancy=2; in_ready=0; 0x12 is held upstream.
  - Then raise out_ready: outputs 0x10, 0x11, 0x12 in order; stall_cnt equals the number of stalled cycles with out_valid=1.
- Flush in TWO:
  - Stimulus: in TWO holding 0x20/0x21, assert flush with in_valid=1, in_data=0x22.
  - Response: next cycle occupancy=0, out_valid=0, out_data=RESET_VALUE; 0x22 is never output; flush_cnt=1.
- Counter saturation: CNT_WIDTH=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15.
- Random: random in_valid and out_ready at 50% over 10k cycles with a scoreboard -> output sequence equals input sequence; occupancy never exceeds 2; no transfer occurs while in_ready=0.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline stage with 2-entry skid buffer, flush and saturating perf counters
module pipe_stage_skid #(
  parameter int unsigned                DATA_WIDTH  = 128,
  parameter logic [DATA_WIDTH-1:0]      RESET_VALUE = '0,
  parameter int unsigned                CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  output logic [CNT_WIDTH-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_main;
  logic [DATA_WIDTH-1:0] r_skid;
  logic [CNT_WIDTH-1:0]  r_stall_cnt;
  logic [CNT_WIDTH-1:0]  r_flush_cnt;

  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] w_main_nxt;
  logic [DATA_WIDTH-1:0] w_skid_nxt;
  logic                  w_acc;
  logic                  w_rel;

  // Handshake outputs come straight from the state register, so out_ready never reaches in_ready.
  assign in_ready  = (r_state != S_TWO);
  assign out_valid = (r_state != S_EMPTY);
  assign out_data  = r_main;
  assign occupancy = r_state;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  assign w_acc = in_valid & in_ready;
  assign w_rel = out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    case (r_state)
      S_EMPTY: begin
        if (w_acc) begin
          w_main_nxt  = in_data;
          w_state_nxt = S_ONE;
        end
      end
      S_ONE: begin
        if (w_acc && w_rel) begin
          w_main_nxt = in_data;
        end else if (w_acc) begin
          w_skid_nxt  = in_data;
          w_state_nxt = S_TWO;
        end else if (w_rel) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_TWO: begin
        if (w_rel) begin
          w_main_nxt  = r_skid;
          w_state_nxt = S_ONE;
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
      end
    endcase
    // A same-cycle accept is dropped; a same-cycle release was already sampled downstream.
    if (flush) begin
      w_state_nxt = S_EMPTY;
      w_main_nxt  = RESET_VALUE;
      w_skid_nxt  = RESET_VALUE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_EMPTY;
      r_main  <= RESET_VALUE;
      r_skid  <= RESET_VALUE;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (flush && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

endmodule
